// File: rtl/pipe_operand_bank.sv
// Pipeline register bank carrying NCH forwarded operand channels plus a
// shared valid bit through DEPTH stages, with stall, flush and stall counter.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   stall_i         hold every stage this cycle
//   flush_i         clear every valid bit this cycle (beats stall)
//   valid_i, data_i operand set entering stage 0 (channel c at [c*WIDTH +: WIDTH])
//   valid_o, data_o last stage contents, straight from flops
//   stall_cnt_o     consecutive stall cycles, saturating at 8'hFF
//
// Build option: define PIPE_BANK_ZERO_FLUSH_EN to make a flush also load
// RST_VAL into every data register, so bubbles carry no stale operands.
// Without it a flush clears only the valid bits.

module pipe_operand_bank #(
   parameter int unsigned      WIDTH   = 32,
   parameter int unsigned      NCH     = 2,
   parameter int unsigned      DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 flush_i,
   input  logic                 valid_i,
   input  logic [NCH*WIDTH-1:0] data_i,
   output logic                 valid_o,
   output logic [NCH*WIDTH-1:0] data_o,
   output logic [7:0]           stall_cnt_o
);

   localparam int unsigned DW = NCH * WIDTH;

   // Reset/flush image of one stage: RST_VAL replicated per channel.
   localparam logic [DW-1:0] RST_BUS = {NCH{RST_VAL}};

   generate
      if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
         $error("pipe_operand_bank: DEPTH must be 1..4");
      end
      if (NCH < 1 || NCH > 8) begin : g_bad_nch
         $error("pipe_operand_bank: NCH must be 1..8");
      end
   endgenerate

   logic [DW-1:0] data_q  [DEPTH];
   logic          valid_q [DEPTH];
   logic [7:0]    cnt_q;
   logic          advance;
   logic          count_up;

   // Flush overrides stall, so a stall only holds when no flush is present.
   assign advance  = !flush_i && !stall_i;
   assign count_up = stall_i && !flush_i;

   // Valid chain: cleared by reset and flush, held by stall.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_q[k] <= 1'b0;
         end
      end else if (advance) begin
         valid_q[0] <= valid_i;
         for (int k = 1; k < DEPTH; k++) begin
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   // Data chain: captured regardless of valid_i; flush handling is
   // the only difference between the two builds.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= RST_BUS;
         end
      end else if (flush_i) begin
`ifdef PIPE_BANK_ZERO_FLUSH_EN
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= RST_BUS;
         end
`else
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= data_q[k];
         end
`endif
      end else if (advance) begin
         data_q[0] <= data_i;
         for (int k = 1; k < DEPTH; k++) begin
            data_q[k] <= data_q[k-1];
         end
      end
   end

   // Consecutive-stall counter; saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'h00;
      end else if (count_up) begin
         if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'h01;
         end
      end else begin
         cnt_q <= 8'h00;
      end
   end

   assign valid_o     = valid_q[DEPTH-1];
   assign data_o      = data_q[DEPTH-1];
   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_operand_bank.sv
// Directed bench for pipe_operand_bank: a DEPTH=3 instance driven from a
// vector table, plus a DEPTH=4 instance with non-zero RST_VAL.

module tb_pipe_operand_bank;

   localparam logic [31:0] RV4 = 32'h5A5A_0001;
   localparam logic [63:0] RB4 = {RV4, RV4};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        vin = 1'b0;
   logic [63:0] din = '0;

   logic        v3, v4;
   logic [63:0] d3, d4;
   logic [7:0]  c3, c4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_operand_bank #(
      .WIDTH(32), .NCH(2), .DEPTH(3), .RST_VAL(32'h0)
   ) u_dut3 (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
      .valid_i(vin), .data_i(din),
      .valid_o(v3), .data_o(d3), .stall_cnt_o(c3)
   );

   pipe_operand_bank #(
      .WIDTH(32), .NCH(2), .DEPTH(4), .RST_VAL(RV4)
   ) u_dut4 (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
      .valid_i(vin), .data_i(din),
      .valid_o(v4), .data_o(d4), .stall_cnt_o(c4)
   );

   typedef struct {
      logic        r;
      logic        s;
      logic        f;
      logic        v;
      logic [63:0] d;
      logic        ev;
      logic [63:0] ed;
      logic [7:0]  ec;
   } vec_t;

   vec_t tbl [17];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int n);
      logic [31:0] hi, lo;
      hi = 32'h100 + n;
      lo = 32'h200 + n;
      return {hi, lo};
   endfunction

   task automatic drive(input logic r, input logic s, input logic f,
                        input logic v, input logic [63:0] d);
      rst = r; stall = s; flush = f; vin = v; din = d;
   endtask

   logic [63:0] exp_fd;

   initial begin
      // rst  stall flush valid data        exp_v exp_d     exp_cnt
      tbl[0]  = '{1, 0, 0, 0, 64'h0,        0, 64'h0,      8'd0};
      tbl[1]  = '{1, 0, 0, 0, 64'h0,        0, 64'h0,      8'd0};
      tbl[2]  = '{0, 0, 0, 0, 64'h0,        0, 64'h0,      8'd0};
      tbl[3]  = '{0, 0, 0, 1, 64'hB_0000000A, 0, 64'h0,    8'd0};
      tbl[4]  = '{0, 0, 0, 0, 64'h0,        0, 64'h0,      8'd0};
      tbl[5]  = '{0, 0, 0, 0, 64'h0,        1, 64'hB_0000000A, 8'd0};
      tbl[6]  = '{0, 0, 0, 0, 64'h0,        0, 64'h0,      8'd0};
      tbl[7]  = '{0, 0, 0, 1, pk(1),        0, 64'h0,      8'd0};
      tbl[8]  = '{0, 0, 0, 1, pk(2),        0, 64'h0,      8'd0};
      tbl[9]  = '{0, 0, 0, 1, pk(3),        1, pk(1),      8'd0};
      tbl[10] = '{0, 1, 0, 1, 64'hDEAD,     1, pk(1),      8'd1};
      tbl[11] = '{0, 1, 0, 0, 64'hBEEF,     1, pk(1),      8'd2};
      tbl[12] = '{0, 1, 0, 1, 64'hCAFE,     1, pk(1),      8'd3};
      tbl[13] = '{0, 1, 0, 0, 64'hF00D,     1, pk(1),      8'd4};
      tbl[14] = '{0, 0, 0, 0, 64'h0,        1, pk(2),      8'd0};
      tbl[15] = '{0, 0, 0, 0, 64'h0,        1, pk(3),      8'd0};
      tbl[16] = '{0, 0, 0, 0, 64'h0,        0, 64'h0,      8'd0};

      // Initial reset; the DEPTH=4 instance shows its non-zero RST_VAL.
      drive(1, 0, 0, 0, '0);
      step();
      step();
      chk("rst_v4", {63'h0, v4}, 64'h0);
      chk("rst_d4", d4, RB4);
      chk("rst_c4", {56'h0, c4}, 64'h0);

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].d);
         step();
         chk($sformatf("vec%0d_valid", i), {63'h0, v3}, {63'h0, tbl[i].ev});
         chk($sformatf("vec%0d_data", i), d3, tbl[i].ed);
         chk($sformatf("vec%0d_cnt", i), {56'h0, c3}, {56'h0, tbl[i].ec});
      end

      // Flush together with stall on a full pipe.
      for (int n = 11; n <= 13; n++) begin
         drive(0, 0, 0, 1, pk(n));
         step();
      end
      chk("fill_valid", {63'h0, v3}, 64'h1);
      chk("fill_data", d3, pk(11));
      drive(0, 1, 0, 1, 64'h1234);
      step();
      chk("prestall_cnt", {56'h0, c3}, 64'd1);
      drive(0, 1, 1, 1, 64'h5678);
      step();
`ifdef PIPE_BANK_ZERO_FLUSH_EN
      exp_fd = 64'h0;
`else
      exp_fd = pk(11);
`endif
      chk("flush_valid", {63'h0, v3}, 64'h0);
      chk("flush_cnt", {56'h0, c3}, 64'h0);
      chk("flush_data", d3, exp_fd);
      drive(0, 0, 0, 0, 64'h0);
      step();
      chk("flush_valid_s1", {63'h0, v3}, 64'h0);
      step();
      chk("flush_valid_s2", {63'h0, v3}, 64'h0);

      // Counter saturation.
      drive(0, 1, 0, 0, 64'h0);
      for (int i = 1; i <= 300; i++) begin
         step();
         if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
            chk($sformatf("sat_cnt_%0d", i), {56'h0, c3},
                (i > 255) ? 64'd255 : 64'(i));
         end
      end
      drive(0, 0, 0, 0, 64'h0);
      step();
      chk("sat_clear", {56'h0, c3}, 64'h0);

      // Mid-operation reset on the DEPTH=4 pipe.
      for (int n = 21; n <= 24; n++) begin
         drive(0, 0, 0, 1, pk(n));
         step();
      end
      chk("d4_full_valid", {63'h0, v4}, 64'h1);
      chk("d4_full_data", d4, pk(21));
      drive(1, 0, 0, 1, pk(25));
      step();
      chk("midrst_v4", {63'h0, v4}, 64'h0);
      chk("midrst_d4", d4, RB4);
      chk("midrst_v3", {63'h0, v3}, 64'h0);
      drive(0, 0, 0, 1, pk(26));
      step();
      chk("post_e1_v4", {63'h0, v4}, 64'h0);
      chk("post_e1_d4", d4, RB4);
      drive(0, 0, 0, 0, 64'h0);
      step();
      step();
      chk("post_e3_v4", {63'h0, v4}, 64'h0);
      chk("post_e3_v3", {63'h0, v3}, 64'h1);
      chk("post_e3_d3", d3, pk(26));
      step();
      chk("post_e4_v4", {63'h0, v4}, 64'h1);
      chk("post_e4_d4", d4, pk(26));
      step();
      chk("post_e5_v4", {63'h0, v4}, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
